// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer.
// Optional feature macro used by the top: PISO_PARITY_EN.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Per-word bit order selector values.
  localparam logic ORDER_MSB = 1'b0;
  localparam logic ORDER_LSB = 1'b1;

  // Number of serial beats per frame, including the optional parity bit.
  function automatic int frame_len(input int width, input bit parity);
    return parity ? width + 1 : width;
  endfunction

endpackage

// File: rtl/piso_serializer_hs.sv
// Parallel-in/serial-out serializer with valid/ready on both sides.
// A word is captured with its bit order and shifted out one bit per
// accepted output beat; a new word may load on the last-bit beat so
// frames run back to back with no idle cycle.
// Build option: define PISO_PARITY_EN to append an even-parity bit.
module piso_serializer_hs
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_lsb_first,
  output logic             dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_first,
  output logic             dout_last,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int              FRAME_LEN = frame_len(WIDTH, PAR_EN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lsb;

  logic w_shift;
  logic w_first;
  logic w_last;
  logic w_accept;
  logic w_beat;
  logic w_data_bit;
  logic w_bit;

`ifdef PISO_PARITY_EN
  logic r_par;
`endif

  // Frame flags and handshakes; outputs depend only on registered state,
  // s_ready is the one output that looks at dout_ready.
  always_comb begin
    w_shift    = (r_state == ST_SHIFT);
    w_first    = w_shift && (r_cnt == '0);
    w_last     = w_shift && (r_cnt == LAST_CNT);
    s_ready    = !w_shift || (w_last && dout_ready);
    w_accept   = s_valid && s_ready;
    w_beat     = w_shift && dout_ready;
    w_data_bit = (r_lsb == ORDER_LSB) ? r_shreg[0] : r_shreg[WIDTH-1];
`ifdef PISO_PARITY_EN
    // Counter value WIDTH is the beat after all data bits: the parity slot.
    w_bit      = (r_cnt == CNT_W'(WIDTH)) ? r_par : w_data_bit;
`else
    w_bit      = w_data_bit;
`endif
  end

  assign dout       = w_shift && w_bit;
  assign dout_valid = w_shift;
  assign dout_first = w_first;
  assign dout_last  = w_last;
  assign busy       = w_shift;

  // FSM, shift register and beat counter. Accept wins over the plain
  // last-beat return to IDLE so a waiting word loads with no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_lsb   <= ORDER_MSB;
    end else if (w_accept) begin
      r_state <= ST_SHIFT;
      r_shreg <= s_data;
      r_cnt   <= '0;
      r_lsb   <= s_lsb_first;
    end else if (w_beat) begin
      if (w_last) begin
        r_state <= ST_IDLE;
        r_shreg <= '0;
        r_cnt   <= '0;
        r_lsb   <= ORDER_MSB;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
        r_shreg <= (r_lsb == ORDER_LSB) ? {1'b0, r_shreg[WIDTH-1:1]}
                                        : {r_shreg[WIDTH-2:0], 1'b0};
      end
    end
  end

`ifdef PISO_PARITY_EN
  // Even parity of the captured word; bit order does not affect it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_par <= 1'b0;
    else if (w_accept)         r_par <= ^s_data;
    else if (w_beat && w_last) r_par <= 1'b0;
  end
`endif

endmodule
